// File: rtl/seg_sched_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
//   - sched_state_e : scheduler FSM states
//   - sel_e         : cur_sel (display owner) encoding
//   - DATA_W, POINT_W, CNT_W : bundle and counter widths
package seg_sched_pkg;

    localparam int unsigned DATA_W  = 20;
    localparam int unsigned POINT_W = 6;
    localparam int unsigned CNT_W   = 26;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShowA = 2'd1,
        StShowB = 2'd2,
        StGap   = 2'd3
    } sched_state_e;

    typedef enum logic [1:0] {
        SelNone = 2'b00,
        SelA    = 2'b01,
        SelB    = 2'b10
    } sel_e;

endpackage

// File: rtl/seg_slot_cnt.sv
// Slot counter shared by the dwell and blanking phases.
// Counts 0..tc_val_i while enabled and wraps to 0 after the terminal count.
//   clk_i    : clock
//   rst_ni   : synchronous active-low reset
//   clr_i    : force the count to 0 (wins over en_i)
//   en_i     : advance the count
//   tc_val_i : terminal count value
//   tc_o     : count equals tc_val_i
module seg_slot_cnt
    import seg_sched_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] tc_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == tc_val_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_disp_sched.sv
// Time-shares one six-digit display between sources A and B.
// A source owns the display for a dwell slot; every change of owner passes through a
// blanking gap, and the display is released (all zero) when nobody requests it.
//   sys_clk, sys_rst_n         : clock, synchronous active-low reset
//   req_a/b                    : level requests to own the display
//   data/point/sign/seg_en_a/b : source bundles
//   data, point, sign, seg_en  : forwarded bundle (zero in idle and gap)
//   cur_sel                    : display owner, 00 none, 01 A, 10 B
//   slot_end                   : one-cycle pulse on the last cycle of each dwell slot
module seg_disp_sched
    import seg_sched_pkg::*;
#(
    parameter logic [CNT_W-1:0] DWELL_MAX = 26'd49_999_999,
    parameter logic [CNT_W-1:0] GAP_MAX   = 26'd4_999_999
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               req_a,
    input  logic               req_b,
    input  logic [DATA_W-1:0]  data_a,
    input  logic [DATA_W-1:0]  data_b,
    input  logic [POINT_W-1:0] point_a,
    input  logic [POINT_W-1:0] point_b,
    input  logic               sign_a,
    input  logic               sign_b,
    input  logic               seg_en_a,
    input  logic               seg_en_b,
    output logic [DATA_W-1:0]  data,
    output logic [POINT_W-1:0] point,
    output logic               sign,
    output logic               seg_en,
    output logic [1:0]         cur_sel,
    output logic               slot_end
);

    sched_state_e state_q, state_d;
    // Destination of the gap: 0 = A, 1 = B.
    logic target_q, target_d;

    logic             cnt_clr, cnt_en, cnt_tc;
    logic [CNT_W-1:0] tc_val;

    logic [DATA_W-1:0]  data_q, data_d;
    logic [POINT_W-1:0] point_q, point_d;
    logic               sign_q, sign_d;
    logic               seg_en_q, seg_en_d;
    logic [1:0]         cur_sel_q, cur_sel_d;
    logic               slot_end_q, slot_end_d;

    logic own_req, oth_req, tgt_req, alt_req, in_show;

    assign tc_val = (state_q == StGap) ? GAP_MAX : DWELL_MAX;

    seg_slot_cnt u_slot_cnt (
        .clk_i    (sys_clk),
        .rst_ni   (sys_rst_n),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .tc_val_i (tc_val),
        .tc_o     (cnt_tc)
    );

    assign in_show = (state_q == StShowA) || (state_q == StShowB);
    assign own_req = (state_q == StShowA) ? req_a : req_b;
    assign oth_req = (state_q == StShowA) ? req_b : req_a;
    assign tgt_req = target_q ? req_b : req_a;
    assign alt_req = target_q ? req_a : req_b;

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_clr = 1'b1;
                if (req_a) begin
                    state_d = StShowA;
                end else if (req_b) begin
                    state_d = StShowB;
                end
            end
            StShowA, StShowB: begin
                if (cnt_tc || !own_req) begin
                    cnt_clr = 1'b1;
                    if (oth_req) begin
                        state_d  = StGap;
                        target_d = (state_q == StShowA);
                    end else if (!own_req) begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            StGap: begin
                if (cnt_tc) begin
                    cnt_clr = 1'b1;
                    if (tgt_req) begin
                        state_d = target_q ? StShowB : StShowA;
                    end else if (alt_req) begin
                        state_d = target_q ? StShowA : StShowB;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output mux; registered one cycle behind the state.
    always_comb begin
        data_d     = '0;
        point_d    = '0;
        sign_d     = 1'b0;
        seg_en_d   = 1'b0;
        cur_sel_d  = SelNone;
        slot_end_d = in_show && cnt_tc;
        if (state_q == StShowA) begin
            data_d    = data_a;
            point_d   = point_a;
            sign_d    = sign_a;
            seg_en_d  = seg_en_a;
            cur_sel_d = SelA;
        end else if (state_q == StShowB) begin
            data_d    = data_b;
            point_d   = point_b;
            sign_d    = sign_b;
            seg_en_d  = seg_en_b;
            cur_sel_d = SelB;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= StIdle;
            target_q   <= 1'b0;
            data_q     <= '0;
            point_q    <= '0;
            sign_q     <= 1'b0;
            seg_en_q   <= 1'b0;
            cur_sel_q  <= SelNone;
            slot_end_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            data_q     <= data_d;
            point_q    <= point_d;
            sign_q     <= sign_d;
            seg_en_q   <= seg_en_d;
            cur_sel_q  <= cur_sel_d;
            slot_end_q <= slot_end_d;
        end
    end

    assign data     = data_q;
    assign point    = point_q;
    assign sign     = sign_q;
    assign seg_en   = seg_en_q;
    assign cur_sel  = cur_sel_q;
    assign slot_end = slot_end_q;

endmodule

// File: tb/tb_seg_disp_sched.sv
// Self-checking bench for seg_disp_sched with short slots (10-cycle dwell, 3-cycle gap).
// A behavioural owner/age model predicts every output each cycle.
module tb_seg_disp_sched;

    localparam int SLOT_LEN = 10;
    localparam int GAP_LEN  = 3;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        req_a, req_b;
    logic [19:0] data_a, data_b;
    logic [5:0]  point_a, point_b;
    logic        sign_a, sign_b, seg_en_a, seg_en_b;
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign, seg_en, slot_end;
    logic [1:0]  cur_sel;

    always #5 sys_clk = ~sys_clk;

    seg_disp_sched #(
        .DWELL_MAX (26'd9),
        .GAP_MAX   (26'd2)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req_a     (req_a),
        .req_b     (req_b),
        .data_a    (data_a),
        .data_b    (data_b),
        .point_a   (point_a),
        .point_b   (point_b),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .seg_en_a  (seg_en_a),
        .seg_en_b  (seg_en_b),
        .data      (data),
        .point     (point),
        .sign      (sign),
        .seg_en    (seg_en),
        .cur_sel   (cur_sel),
        .slot_end  (slot_end)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: owner 0 = nobody, 1 = A, 2 = B, 3 = blanking; age = cycles spent in this phase.
    int m_owner = 0;
    int m_age   = 0;
    int m_dest  = 1;

    logic [19:0] e_data;
    logic [5:0]  e_point;
    logic        e_sign, e_seg_en, e_slot_end;
    logic [1:0]  e_cur_sel;

    bit fix_a = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit wants(input int src);
        return (src == 1) ? req_a : req_b;
    endfunction

    task automatic go_to(input int owner);
        m_owner = owner;
        m_age   = 0;
    endtask

    task automatic model_step();
        int x;
        if (!sys_rst_n) begin
            {e_data, e_point, e_sign, e_seg_en, e_slot_end, e_cur_sel} = '0;
            go_to(0);
            m_dest = 1;
        end else begin
            e_data     = (m_owner == 1) ? data_a : (m_owner == 2) ? data_b : 20'd0;
            e_point    = (m_owner == 1) ? point_a : (m_owner == 2) ? point_b : 6'd0;
            e_sign     = (m_owner == 1) ? sign_a : (m_owner == 2) ? sign_b : 1'b0;
            e_seg_en   = (m_owner == 1) ? seg_en_a : (m_owner == 2) ? seg_en_b : 1'b0;
            e_cur_sel  = (m_owner == 1 || m_owner == 2) ? 2'(m_owner) : 2'd0;
            e_slot_end = (m_owner == 1 || m_owner == 2) && (m_age + 1 == SLOT_LEN);
            if (m_owner == 0) begin
                if (req_a) go_to(1);
                else if (req_b) go_to(2);
            end else if (m_owner == 3) begin
                if (m_age + 1 < GAP_LEN) m_age++;
                else if (wants(m_dest)) go_to(m_dest);
                else if (wants(3 - m_dest)) go_to(3 - m_dest);
                else go_to(0);
            end else begin
                x = m_owner;
                if (m_age + 1 == SLOT_LEN || !wants(x)) begin
                    if (wants(3 - x)) begin
                        go_to(3);
                        m_dest = 3 - x;
                    end else if (wants(x)) begin
                        go_to(x);
                    end else begin
                        go_to(0);
                    end
                end else begin
                    m_age++;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_val("data", 32'(data), 32'(e_data));
        check_val("point", 32'(point), 32'(e_point));
        check_val("sign", 32'(sign), 32'(e_sign));
        check_val("seg_en", 32'(seg_en), 32'(e_seg_en));
        check_val("cur_sel", 32'(cur_sel), 32'(e_cur_sel));
        check_val("slot_end", 32'(slot_end), 32'(e_slot_end));
    endtask

    task automatic drive_rand();
        if (!fix_a) begin
            data_a   = 20'($urandom);
            point_a  = 6'($urandom);
            sign_a   = 1'($urandom);
            seg_en_a = ($urandom_range(0, 7) != 0);
        end
        data_b   = 20'($urandom);
        point_b  = 6'($urandom);
        sign_b   = 1'($urandom);
        seg_en_b = ($urandom_range(0, 7) != 0);
    endtask

    // Inputs are changed 1 time unit after the edge, so they are stable at the next edge.
    task automatic tick();
        @(posedge sys_clk);
        model_step();
        #1;
        compare_all();
        drive_rand();
    endtask

    task automatic go_idle();
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        sys_rst_n = 1'b0;
        req_a     = 1'b1;
        req_b     = 1'b1;
        drive_rand();

        // Reset held with both requests high, then A granted.
        repeat (3) tick();
        check_val("rst_sel", 32'(cur_sel), 32'd0);
        sys_rst_n = 1'b1;
        repeat (2) tick();
        check_val("rst_grant_a", 32'(cur_sel), 32'd1);
        go_idle();

        // A alone with fixed content.
        fix_a    = 1'b1;
        data_a   = 20'd123456;
        point_a  = 6'b000100;
        sign_a   = 1'b0;
        seg_en_a = 1'b1;
        req_a    = 1'b1;
        repeat (35) tick();
        check_val("a_only_data", 32'(data), 32'd123456);
        fix_a = 1'b0;

        // Both requesting: alternation through gaps.
        req_b = 1'b1;
        repeat (60) tick();
        go_idle();

        // Early release with nobody else waiting.
        req_a = 1'b1;
        tick();
        repeat (4) tick();
        req_a = 1'b0;
        repeat (2) tick();
        check_val("early_rel_idle", 32'(cur_sel), 32'd0);
        go_idle();

        // Early release with B waiting: gap then B.
        req_a = 1'b1;
        tick();
        repeat (4) tick();
        req_a = 1'b0;
        req_b = 1'b1;
        repeat (8) tick();
        check_val("early_rel_b", 32'(cur_sel), 32'd2);
        go_idle();

        // B withdraws once the gap starts; display returns to A.
        req_a = 1'b1;
        tick();
        req_b = 1'b1;
        for (int i = 0; i < 30 && m_owner != 3; i++) tick();
        check_val("gap_reached", 32'(m_owner), 32'd3);
        req_b = 1'b0;
        repeat (6) tick();
        check_val("gap_return_a", 32'(cur_sel), 32'd1);
        go_idle();

        // Reset in the middle of a B slot.
        req_b = 1'b1;
        tick();
        repeat (5) tick();
        sys_rst_n = 1'b0;
        req_a     = 1'b1;
        tick();
        check_val("mid_rst_sel", 32'(cur_sel), 32'd0);
        check_val("mid_rst_data", 32'(data), 32'd0);
        sys_rst_n = 1'b1;
        repeat (2) tick();
        check_val("mid_rst_grant_a", 32'(cur_sel), 32'd1);

        // Random request/reset traffic.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0) req_a = ~req_a;
            if ($urandom_range(0, 7) == 0) req_b = ~req_b;
            sys_rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
